bcd_xs3_stream: RTL

Digit-serial, multi-digit BCD ↔ excess-3 converter with valid/ready handshakes on both sides. It is the parametrised successor to the single-digit combinational BCD-to-excess-3 converter. It accepts a packed word of `DIGITS` 4-bit codes and converts one digit per clock, LSB digit first. It supports both conversion directions and flags invalid digits. It sits between BCD-producing front ends (counters, keypad decoders) and excess-3 arithmetic/display logic.

---
 rtl/bcd_xs3_stream.sv | 97 +++++++++
 1 files changed

// File: rtl/bcd_xs3_stream.sv
// bcd_xs3_stream: digit-serial BCD <-> excess-3 converter, one digit per clock, LSB digit first.
// Optional macro BCDX_ERRCHK_EN: invalid digits are forced to 4'hF and set the sticky out_err.
module bcd_xs3_stream #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_data,
   input  logic                  mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_data,
   output logic                  out_err
);
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONV = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          r_state;
   logic [CW-1:0]       r_cnt;
   logic [4*DIGITS-1:0] r_in;
   logic [4*DIGITS-1:0] r_out;
   logic                r_mode;
   logic                r_err;

   logic [3:0]          w_dig;
   logic [3:0]          w_res;
   logic                w_bad;
   logic                w_last;

   always_comb begin
      w_dig = 4'd0;
      for (int k = 0; k < DIGITS; k++)
         if (int'(r_cnt) == k) w_dig = r_in[4*k +: 4];
   end

   assign w_last = (int'(r_cnt) == DIGITS - 1);

   // Plain 4-bit modular +/-3; carry/borrow is discarded.
`ifdef BCDX_ERRCHK_EN
   assign w_bad = r_mode ? ((w_dig < 4'd3) || (w_dig > 4'd12)) : (w_dig > 4'd9);
   assign w_res = w_bad ? 4'hF : (r_mode ? w_dig - 4'd3 : w_dig + 4'd3);
`else
   assign w_bad = 1'b0;
   assign w_res = r_mode ? w_dig - 4'd3 : w_dig + 4'd3;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_in    <= '0;
         r_out   <= '0;
         r_mode  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_in    <= in_data;
                  r_mode  <= mode;
                  r_cnt   <= '0;
                  r_out   <= '0;
                  r_err   <= 1'b0;
                  r_state <= S_CONV;
               end
            end
            S_CONV: begin
               for (int k = 0; k < DIGITS; k++)
                  if (int'(r_cnt) == k) r_out[4*k +: 4] <= w_res;
               r_err <= r_err | w_bad;
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // State sits at IDLE during reset, so gate ready on rst directly.
   assign in_ready  = (r_state == S_IDLE) && !rst;
   assign out_valid = (r_state == S_DONE);
   assign out_data  = r_out;
   assign out_err   = r_err;

endmodule
